pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4: number of pipeline stages, legal range 1..WIDTH. Each stage SHALL add a WIDTH/STAGES-bit slice.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand set present on in_1, in_2, c_in and sub.
REQ-006 in_ready  output  1  block can accept an operand set this cycle.
REQ-007 in_1  input  WIDTH  first operand.
REQ-008 in_2  input  WIDTH  second operand.
REQ-009 c_in  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result fields below are valid.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry out of the MSB. In subtract mode it is the inverted borrow: 1 = no borrow.
REQ-015 overflow  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Operation: sub=0 SHALL compute {c_out,sum} = in_1 + in_2 + c_in; sub=1 SHALL compute in_1 + ~in_2 + 1, with c_in ignored. All arithmetic is WIDTH+1 bits wide and is modulo 2^WIDTH for sum.
REQ-018 Slicing: stage k SHALL add bits [(k+1)*W/S-1 : k*W/S] using the registered carry from stage k-1. Higher-order unconsumed operand bits and already-computed lower sum bits SHALL be carried forward in stage registers; no full-width carry chain is permitted within one cycle.
REQ-019 Handshake: a transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-021 Stall: while out_valid && !out_ready, every stage register, including valid bits, SHALL hold its value, and sum, c_out, overflow and zero SHALL remain stable.
REQ-022 Latency: with no stall, an accepted operand set SHALL appear with out_valid=1 exactly STAGES cycles after acceptance.
REQ-023 Throughput: one operand set per cycle; back-to-back results SHALL emerge in acceptance order with no gaps.
REQ-024 Bubbles: cycles without a transfer in SHALL propagate as valid=0 stages; bubbles SHALL NOT be collapsed.
REQ-025 Flags: overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the effective second operand (in_2 or ~in_2). zero SHALL be computed from the final full sum. Both SHALL be registered alongside sum.
REQ-026 Simultaneous transfer in and out in the same cycle SHALL be legal, and the pipeline SHALL advance.
REQ-027 When out_valid=0, sum, c_out, overflow and zero are don't-care; the bench SHALL NOT check them.
REQ-028 STAGES=1 SHALL degenerate to a single registered full-width adder with latency 1.

Reset
REQ-029 rst_n low SHALL asynchronously clear every stage valid bit, out_valid, sum, c_out, overflow and zero to 0.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operand sets; no result from before reset SHALL emerge afterward.
REQ-032 The first acceptance SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 Add with carry: in_1=FFFFFFFF, in_2=FFFFFFFF, c_in=0, sub=0 -> after 4 cycles sum=FFFFFFFE, c_out=1, overflow=0, zero=0.
REQ-034 Cross-slice carry: in_1=ABCDABCD, in_2=AAAAAAAA, c_in=0 -> sum=56785677, c_out=1, overflow=1 (two negative operands give a positive result).
REQ-035 Subtract and signed overflow, back to back:
- 00000005 - 00000007 -> FFFFFFFE, c_out=0, overflow=0.
- 7FFFFFFF + 00000001 -> 80000000, overflow=1.
- 00000001 + FFFFFFFF, c_in=0 -> 00000000, zero=1, c_out=1.
- Results SHALL appear on consecutive cycles, in order.
REQ-036 Backpressure: stream 6 operand sets with out_ready=0 from cycle 5 to cycle 8.
- in_ready SHALL be 0 while stalled.
- Outputs SHALL hold.
- All 6 results SHALL emerge in order with none lost or duplicated.
REQ-037 Reset mid-flight: accept 3 sets, then assert rst_n=0 asynchronously between edges.
- out_valid SHALL drop to 0 immediately.
- After release, no stale result SHALL appear.
REQ-038 Parametric: WIDTH=16, STAGES=2, in_1=8ABC, in_2=8234, c_in=1 -> latency 2, sum=0CF1, c_out=1, overflow=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Ripple-carry adder/subtractor split into STAGES registered slices of WIDTH/STAGES bits,
// with a valid/ready handshake that stalls the whole pipeline under backpressure.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SW  = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;
    localparam int L   = STAGES - 1;

    // Per-stage registers: operands travel with the partial sum so each stage only adds its slice.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  a_n [STAGES];
    logic [WIDTH-1:0]  b_n [STAGES];
    logic [WIDTH-1:0]  s_n [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [SW:0]       slice [STAGES];
    logic [STAGES-1:0] c_n;
    logic [STAGES-1:0] c_d;
    logic              ovf_d;
    logic              zero_d;
    logic              advance;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    always_comb begin
        // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
        a_n[0] = in_1;
        b_n[0] = sub ? ~in_2 : in_2;
        s_n[0] = '0;
        c_n[0] = sub | c_in;
        for (int k = 1; k < STAGES; k++) begin
            a_n[k] = a_q[k-1];
            b_n[k] = b_q[k-1];
            s_n[k] = s_q[k-1];
            c_n[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_n[k][k*SW +: SW]} + {1'b0, b_n[k][k*SW +: SW]} + {{SW{1'b0}}, c_n[k]};
            s_d[k]   = s_n[k];
            s_d[k][k*SW +: SW] = slice[k][SW-1:0];
            c_d[k]   = slice[k][SW];
        end
        // Flags use the effective second operand and the complete sum leaving the last stage.
        ovf_d  = (a_n[L][MSB] == b_n[L][MSB]) && (s_d[L][MSB] != a_n[L][MSB]);
        zero_d = (s_d[L] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_n[k];
                b_q[k] <= b_n[k];
                s_q[k] <= s_d[k];
            end
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign c_out     = c_q[L];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench: expected results are queued at acceptance and compared by a monitor when
// the adder hands out a result; a second 16-bit/2-stage instance covers the parametric case.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, c_in, sub;
    logic [31:0] in_1, in_2, sum;
    logic        out_valid, out_ready, c_out, overflow, zero;

    logic        p_in_valid, p_in_ready, p_c_in, p_sub;
    logic [15:0] p_in_1, p_in_2, p_sum;
    logic        p_out_valid, p_out_ready, p_c_out, p_overflow, p_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] sum;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } res_t;

    res_t sb[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_1(in_1), .in_2(in_2), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_1(p_in_1), .in_2(p_in_2), .c_in(p_c_in), .sub(p_sub),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .sum(p_sum),
        .c_out(p_c_out), .overflow(p_overflow), .zero(p_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops on every output transfer; during a stall checks that the head result holds.
    always @(negedge clk) begin : monitor
        res_t e;
        if (rst_n && out_valid) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got sum %h expected no result", sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", sum, e.sum);
                    check("c_out", {31'b0, c_out}, {31'b0, e.c_out});
                    check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                    check("zero", {31'b0, zero}, {31'b0, e.zero});
                end
            end else begin
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                if (sb.size() != 0) begin
                    check("stall_hold_sum", sum, sb[0].sum);
                    check("stall_hold_c_out", {31'b0, c_out}, {31'b0, sb[0].c_out});
                end
            end
        end
    end

    // Presents one operand set, holds it until accepted, and queues its expected result.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s,
                         input logic [31:0] es, input logic ec, input logic eo, input logic ez,
                         input bit track);
        in_1 = a; in_2 = b; c_in = ci; sub = s; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (track) sb.push_back(res_t'{es, ec, eo, ez});
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout: got no acceptance of %h expected acceptance within 20 cycles", a);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cnt;
        rst_n = 1'b0; in_valid = 1'b0; in_1 = '0; in_2 = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        p_in_valid = 1'b0; p_in_1 = '0; p_in_2 = '0; p_c_in = 1'b0; p_sub = 1'b0; p_out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_sum", sum, 32'd0);
        check("rst_p_out_valid", {31'b0, p_out_valid}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Add with carry, with exact latency of 4
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("latency_valid", {31'b0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) @(posedge clk);
        end
        @(posedge clk); #1;

        // Carry across slices with signed overflow
        drive(32'hABCD_ABCD, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h5678_5677, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back subtract / overflow / zero
        drive(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("b2b_first_valid", {31'b0, out_valid}, 32'd1);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("b2b_consecutive", {31'b0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        drain();

        // Backpressure: out_ready low in cycles 5..8 of a 6-set stream
        fork
            begin
                drive(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b1);
                drive(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 1'b1);
                drive(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
                drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
                drive(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
                drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight: three untracked sets stalled at the output, then async reset
        out_ready = 1'b0;
        drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("midrst_pre_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_sum", sum, 32'd0);
        @(posedge clk);
        @(posedge clk); #4;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("midrst_no_stale", cnt, 32'd0);
        @(posedge clk); #1;

        // Parametric instance: 16-bit, 2 stages, latency 2
        p_in_1 = 16'h8ABC; p_in_2 = 16'h8234; p_c_in = 1'b1; p_sub = 1'b0; p_in_valid = 1'b1;
        @(negedge clk);
        check("p_in_ready", {31'b0, p_in_ready}, 32'd1);
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        @(negedge clk);
        check("p_latency_c1", {31'b0, p_out_valid}, 32'd0);
        @(negedge clk);
        check("p_latency_c2", {31'b0, p_out_valid}, 32'd1);
        check("p_sum", {16'b0, p_sum}, 32'h0000_0CF1);
        check("p_c_out", {31'b0, p_c_out}, 32'd1);
        check("p_overflow", {31'b0, p_overflow}, 32'd1);
        check("p_zero", {31'b0, p_zero}, 32'd0);
        @(posedge clk); #1;

        check("final_sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
